spi_slave_frame_ctrl: RTL
=========================

Name: spi_slave_frame_ctrl

Overview:
Sequencer for the SPI converter receive/transmit path in SPI mode 0 (CPOL=0, CPHA=0).
- Synchronises the external SPI pins into the sysclk domain and detects sclk edges.
- Frames words on spi_cs_n, counts bits, shifts MOSI in and MISO out.
- Hands complete words to the fabric over valid/ready, with overrun and underrun tracking.

Parameters:
DATA_WIDTH, 8, bits per SPI word (2..32)
SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_cs_n, spi_mosi (>=2)

Ports:
sysclk  in  1  system clock; must be >= 4x spi_sclk frequency
sysrst  in  1  asynchronous, active-high reset
spi_sclk  in  1  external SPI clock
spi_cs_n  in  1  external chip select, active low
spi_mosi  in  1  external serial data in
spi_miso  out  1  serial data out, MSB first
tx_data  in  DATA_WIDTH  word to transmit
tx_valid  in  1  tx_data available
tx_ready  out  1  one-cycle pulse when tx_data is taken
rx_data  out  DATA_WIDTH  received word
rx_valid  out  1  rx_data held valid until accepted
rx_ready  in  1  consumer accepts rx_data
frame_active  out  1  high while state is not IDLE
overrun_err  out  1  sticky: word lost because rx buffer was full
underrun_err  out  1  sticky: word loaded while tx_valid was low
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (sysrst high, any time): all outputs 0, state IDLE, bit counter 0, shift registers 0, synchronisers 0 except spi_cs_n chain = 1.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one additional delay flop.
  - rise = sclk_s & ~sclk_d
  - fall = ~sclk_s & sclk_d
  - cs_start = ~cs_s & cs_d
- FSM states:
  - IDLE: on cs_start -> LOAD.
  - LOAD (1 cycle):
    - If tx_valid: tx_shift <= tx_data and tx_ready pulses.
    - Else: tx_shift <= 0 and underrun_err <= 1.
    - bit_cnt <= 0, then -> SHIFT.
  - SHIFT:
    - On rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s} and bit_cnt++.
    - On fall: tx_shift shifts left by 1.
    - When rise occurs with bit_cnt == DATA_WIDTH-1 -> WORD.
  - WORD (1 cycle):
    - Deliver the word to the rx buffer.
    - Reload tx_shift exactly as in LOAD.
    - bit_cnt <= 0, then -> SHIFT. Consecutive words continue within one frame.
- spi_miso = tx_shift[DATA_WIDTH-1] in every state except IDLE, where it is 0.
- Rx buffer (single entry):
  - On WORD with rx_valid=0, or with rx_valid=1 & rx_ready=1 in the same cycle: rx_data <= rx_shift, rx_valid <= 1.
  - On WORD with rx_valid=1 & rx_ready=0: new word discarded, old word kept, overrun_err <= 1.
  - rx_valid & rx_ready outside WORD: rx_valid <= 0 next cycle.
- rx_valid rises one sysclk after WORD. Last sampling rise to rx_valid = 2 sysclk cycles (after sync latency).
- CS deassert (cs_s=1) in LOAD/SHIFT/WORD:
  - Immediate -> IDLE.
  - Partial word discarded, no rx_valid.
  - A tx word already taken is dropped.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the event wins (flag stays 1).
- bit_cnt width = $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1.

Optional Feature:
Macro SPI_FRAME_CNT_EN.
- Defined: adds output port frame_count [15:0].
  - Increments by 1 on each CS deassert that follows at least one completed WORD.
  - Wraps from 0xFFFF to 0. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single frame: DATA_WIDTH=8, tx_data=0xA5 with tx_valid=1, MOSI sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid=1; tx_ready exactly one pulse; no error flags.
- Two-word frame: tx_valid=1 providing 0x11 then 0x22, MOSI sends 0xF0, 0x0F, rx_ready held 1 -> rx words 0xF0, 0x0F in order; tx_ready two pulses; MISO carries 0x11 then 0x22.
- Overrun: rx_ready=0, two words received -> rx_data stays at the first word, overrun_err=1. Then err_clr pulse -> overrun_err=0.
- Underrun: tx_valid=0 at frame start -> MISO all zeros, underrun_err=1, tx_ready never pulses.
- Abort: CS deasserted after 5 rising edges -> no rx_valid; frame_active=0 within SYNC_STAGES+2 cycles. The next full frame receives correctly.
- Reset: sysrst asserted mid-word -> all outputs 0 immediately. After release, a full frame works. With SPI_FRAME_CNT_EN defined, frame_count=0 after reset and 1 after the next completed frame.

Source files
------------

// File: rtl/spi_slave_frame_ctrl.sv
// rtl/spi_slave_frame_ctrl.sv - SPI mode-0 slave word framer with rx/tx handshakes (optional SPI_FRAME_CNT_EN frame counter)
module spi_slave_frame_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sysclk,
   input  logic                  sysrst,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  frame_active,
   output logic                  overrun_err,
   output logic                  underrun_err,
   input  logic                  err_clr
`ifdef SPI_FRAME_CNT_EN
   ,
   output logic [15:0]           frame_count
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_WORD} state_t;

   state_t                  state, state_next;
   logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
   logic                    sclk_d, cs_d;
   logic                    sclk_s, cs_s, mosi_s;
   logic                    rise, fall, cs_start;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0]   rx_shift, tx_shift;
   logic                    load_tx, deliver, abort;
   logic                    shift_in, shift_out;
   logic                    underrun_set, overrun_set;
   logic                    underrun_pending;

   assign sclk_s   = sclk_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign rise     = sclk_s & ~sclk_d;
   assign fall     = ~sclk_s & sclk_d;
   assign cs_start = ~cs_s & cs_d;

   // Pin synchronisers plus one delay flop for edge detection; cs chain idles deasserted
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   // Frame state register
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_next = state;
      load_tx    = 1'b0;
      deliver    = 1'b0;
      abort      = 1'b0;
      shift_in   = 1'b0;
      shift_out  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (cs_s) begin
               abort      = 1'b1;
               state_next = ST_IDLE;
            end else begin
               load_tx    = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_s) begin
               abort      = 1'b1;
               state_next = ST_IDLE;
            end else begin
               shift_in  = rise;
               // bit_cnt==0 means the fall trails the previous word's last rise;
               // shifting there would throw away the freshly loaded MSB
               shift_out = fall & (bit_cnt != '0);
               if (rise && bit_cnt == LAST_BIT) state_next = ST_WORD;
            end
         end
         ST_WORD: begin
            // The word is complete, so it is delivered even if cs rises now
            deliver = 1'b1;
            if (cs_s) begin
               abort      = 1'b1;
               state_next = ST_IDLE;
            end else begin
               load_tx    = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      tx_ready = load_tx & tx_valid;
   end

   assign frame_active = (state != ST_IDLE);
   assign spi_miso     = (state != ST_IDLE) ? tx_shift[DATA_WIDTH-1] : 1'b0;

   // Bit counter and the two shift registers
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
      end else begin
         if (abort || load_tx)                   bit_cnt <= '0;
         else if (shift_in && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
         if (shift_in) rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
         if (load_tx)        tx_shift <= tx_valid ? tx_data : '0;
         else if (shift_out) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign overrun_set = deliver & rx_valid & ~rx_ready;

   // Single-entry receive buffer; a full buffer keeps the older word
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else if (deliver) begin
         if (!rx_valid || rx_ready) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

   // An empty reload between words only counts as underrun once that zero
   // word actually starts shifting; a reload after the last word is harmless
   assign underrun_set = ((state == ST_LOAD) && !cs_s && !tx_valid) ||
                         (underrun_pending && shift_in);

   // Sticky error flags (a new event outranks err_clr) and deferred underrun
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         overrun_err      <= 1'b0;
         underrun_err     <= 1'b0;
         underrun_pending <= 1'b0;
      end else begin
         if (overrun_set)  overrun_err <= 1'b1;
         else if (err_clr) overrun_err <= 1'b0;
         if (underrun_set) underrun_err <= 1'b1;
         else if (err_clr) underrun_err <= 1'b0;
         if (abort || state == ST_LOAD)                     underrun_pending <= 1'b0;
         else if (load_tx && !tx_valid)                     underrun_pending <= 1'b1;
         else if (shift_in)                                 underrun_pending <= 1'b0;
      end
   end

`ifdef SPI_FRAME_CNT_EN
   logic words_done;

   // Count frames that ended with at least one completed word
   always_ff @(posedge sysclk or posedge sysrst) begin
      if (sysrst) begin
         frame_count <= '0;
         words_done  <= 1'b0;
      end else if (abort) begin
         words_done <= 1'b0;
         if (words_done || deliver) frame_count <= frame_count + 16'd1;
      end else if (deliver) begin
         words_done <= 1'b1;
      end
   end
`endif

endmodule
